// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and constants for the UART boot loader.
package boot_pkg;
  typedef enum logic [2:0] {LEN, DATA, ACK, DONE, ERR} state_t;
  localparam logic [7:0] BOOT_ACK_BYTE = 8'hAA;
  localparam int LEN_BYTES = 4;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: boot loader bus bundle.
// master = loader side (takes uart_rx bytes/ferr and tx_busy, drives uart_tx, imem write port, core_rst, done, err);
// slave = the surrounding system.
interface boot_loader_if #(parameter int ADDR_W = 32);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              ferr;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              err;
  modport master (
    input  rx_data, rx_ready, ferr, tx_busy,
    output tx_data, tx_start, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
  modport slave (
    output rx_data, rx_ready, ferr, tx_busy,
    input  tx_data, tx_start, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/boot_byte_asm.sv
// boot_byte_asm: takes one byte per rx_ready rising edge and packs four bytes LSB-first into a word.
// Ports: clk, rstn, rx_data_i/rx_ready_i (uart_rx), word_valid_o (one-cycle pulse with the 4th byte), word_o.
module boot_byte_asm (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_ready_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic        rx_ready_q;
  logic [23:0] sh_q;
  logic [1:0]  cnt_q;
  logic        take;
  assign take = rx_ready_i & ~rx_ready_q;
  // The word is presented combinationally with the 4th byte so the caller can register it on the accepting edge.
  assign word_valid_o = take & (cnt_q == 2'd3);
  assign word_o = {rx_data_i, sh_q};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_ready_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
    end else begin
      rx_ready_q <= rx_ready_i;
      if (take) begin
        sh_q  <= {rx_data_i, sh_q[23:8]};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a word count and program words over UART, writes them to imem, then releases the core.
// Ports: clk, rstn (async active-low), bus (boot_loader_if.master).
// Optional BOOT_ACK_EN: sends 0xAA on uart_tx before completing the load.
module boot_loader
  import boot_pkg::*;
#(
  parameter int MAX_WORDS = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         rstn,
  boot_loader_if.master bus
);
  localparam int CW = $clog2(MAX_WORDS) + 1;
`ifdef BOOT_ACK_EN
  localparam state_t FIN = ACK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t            state_q;
  logic [CW-1:0]     wcnt_q, n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q, done_q, err_q, core_rst_q;
  logic              word_valid;
  logic [31:0]       word;
  boot_byte_asm u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .rx_data_i    (bus.rx_data),
    .rx_ready_i   (bus.rx_ready),
    .word_valid_o (word_valid),
    .word_o       (word)
  );
`ifdef BOOT_ACK_EN
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
`else
  assign bus.tx_data  = '0;
  assign bus.tx_start = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LEN;
      wcnt_q     <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef BOOT_ACK_EN
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`endif
    end else begin
      we_q       <= 1'b0;
      // Core leaves reset one cycle after done rises; done never rises on the error path.
      core_rst_q <= ~done_q;
`ifdef BOOT_ACK_EN
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`endif
      case (state_q)
        LEN: begin
          if (bus.ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (word_valid) begin
            if (word == '0) begin
              state_q <= FIN;
              done_q  <= (FIN == DONE);
            end else if (word > 32'(MAX_WORDS)) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              n_q     <= word[CW-1:0];
              wcnt_q  <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (bus.ferr) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else if (word_valid) begin
            we_q    <= 1'b1;
            wdata_q <= word;
            addr_q  <= ADDR_W'({wcnt_q, 2'b00});
            wcnt_q  <= wcnt_q + CW'(1);
            if (wcnt_q + CW'(1) == n_q) begin
              state_q <= FIN;
              done_q  <= (FIN == DONE);
            end
          end
        end
`ifdef BOOT_ACK_EN
        ACK: begin
          if (!bus.tx_busy) begin
            tx_data_q  <= BOOT_ACK_BYTE;
            tx_start_q <= 1'b1;
            state_q    <= DONE;
            done_q     <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule
